// File: rtl/pc_stack_if.sv
// Fetch-side bundle for pc_stack: control from decode/ALU in, fetch address and stack status out.
interface pc_stack_if #(
    parameter int D    = 10,
    parameter int OFFW = 8,
    parameter int SD   = 4
) ();
    localparam int SPW = $clog2(SD + 1);

    logic            start;
    logic            stall;
    logic [2:0]      op;
    logic            cond;
    logic [D-1:0]    target;
    logic [OFFW-1:0] offset;

    logic [D-1:0]    pc;
    logic            running;
    logic [SPW-1:0]  sp;
    logic            stack_full;
    logic            stack_empty;
    logic            ovf_err;
    logic            unf_err;

    modport master (
        output start, stall, op, cond, target, offset,
        input  pc, running, sp, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  start, stall, op, cond, target, offset,
        output pc, running, sp, stack_full, stack_empty, ovf_err, unf_err
    );
endinterface

// File: rtl/pc_stack.sv
// Program counter for the fetch stage with conditional branches, a call/return
// stack, fetch stall and an IDLE/RUN/HALTED run state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; pc and stack held until start
// RUN     | one pc op per unstalled cycle
// HALTED  | HALT executed; pc and stack held until start or reset
module pc_stack #(
    parameter int D        = 10,
    parameter int OFFW     = 8,
    parameter int SD       = 4,
    parameter int RESET_PC = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    pc_stack_if.slave  bus
);
    localparam int SPW   = $clog2(SD + 1);
    localparam int IDXW  = (SD > 1) ? $clog2(SD) : 1;
    localparam int DEPTH = 2 ** IDXW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NEXT  = 3'b000,
        OP_BREL  = 3'b001,
        OP_BRELC = 3'b010,
        OP_JABS  = 3'b011,
        OP_JABSC = 3'b100,
        OP_CALL  = 3'b101,
        OP_RET   = 3'b110,
        OP_HALT  = 3'b111
    } op_t;

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic [D-1:0]   stack_q [DEPTH];
    logic [D-1:0]   stack_d [DEPTH];

    logic [D-1:0]    pc_inc;
    logic [D-1:0]    pc_rel;
    logic [IDXW-1:0] push_idx;
    logic [IDXW-1:0] pop_idx;
    logic            full;
    logic            empty;
    op_t             op;

    assign op       = op_t'(bus.op);
    assign pc_inc   = pc_q + D'(1);
    // Width cast of a signed operand sign-extends before the modulo-2^D add.
    assign pc_rel   = pc_q + D'($signed(bus.offset));
    assign push_idx = IDXW'(sp_q);
    assign pop_idx  = IDXW'(sp_q - SPW'(1));
    assign full     = (sp_q == SPW'(SD));
    assign empty    = (sp_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;

        if (bus.start) begin
            state_d = ST_RUN;
            pc_d    = D'(RESET_PC);
            sp_d    = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (state_q == ST_RUN && !bus.stall) begin
            unique case (op)
                OP_NEXT:  pc_d = pc_inc;
                OP_BREL:  pc_d = pc_rel;
                OP_BRELC: pc_d = bus.cond ? pc_rel : pc_inc;
                OP_JABS:  pc_d = bus.target;
                OP_JABSC: pc_d = bus.cond ? bus.target : pc_inc;
                OP_CALL: begin
                    pc_d = bus.target;
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = pc_inc;
                        sp_d              = sp_q + SPW'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d = stack_q[pop_idx];
                        sp_d = sp_q - SPW'(1);
                    end
                end
                OP_HALT:  state_d = ST_HALTED;
                default:  pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= D'(RESET_PC);
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.pc          = pc_q;
    assign bus.running     = (state_q == ST_RUN);
    assign bus.sp          = sp_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: hand-computed vector table plus corner
// sequences, expectations queued at drive time and checked after each posedge.
module tb_pc_stack;
    localparam int D    = 10;
    localparam int OFFW = 8;
    localparam int SD   = 4;

    localparam logic [2:0] NEXT  = 3'b000;
    localparam logic [2:0] BREL  = 3'b001;
    localparam logic [2:0] BRELC = 3'b010;
    localparam logic [2:0] JABS  = 3'b011;
    localparam logic [2:0] JABSC = 3'b100;
    localparam logic [2:0] CALL  = 3'b101;
    localparam logic [2:0] RET   = 3'b110;
    localparam logic [2:0] HALT  = 3'b111;

    typedef struct {
        logic        rn;
        logic        st;
        logic        sl;
        logic [2:0]  op;
        logic        c;
        logic [9:0]  tg;
        logic [7:0]  off;
        logic [9:0]  e_pc;
        logic [2:0]  e_sp;
        logic        e_run;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    typedef struct {
        int          idx;
        logic [9:0]  pc;
        logic [2:0]  sp;
        logic        run;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk;
    logic reset_n;

    pc_stack_if #(.D(D), .OFFW(OFFW), .SD(SD)) bus ();

    pc_stack #(.D(D), .OFFW(OFFW), .SD(SD), .RESET_PC(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;

    function automatic vec_t mk(logic rn, logic st, logic sl, logic [2:0] op,
                                logic c, logic [9:0] tg, logic [7:0] off,
                                logic [9:0] e_pc, logic [2:0] e_sp,
                                logic e_run, logic e_ovf, logic e_unf);
        vec_t v;
        v.rn = rn; v.st = st; v.sl = sl; v.op = op; v.c = c; v.tg = tg; v.off = off;
        v.e_pc = e_pc; v.e_sp = e_sp; v.e_run = e_run; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset_n    = v.rn;
        bus.start  = v.st;
        bus.stall  = v.sl;
        bus.op     = v.op;
        bus.cond   = v.c;
        bus.target = v.tg;
        bus.offset = v.off;
        e.idx   = n_vec;
        e.pc    = v.e_pc;
        e.sp    = v.e_sp;
        e.run   = v.e_run;
        e.full  = (v.e_sp == 3'd4);
        e.empty = (v.e_sp == 3'd0);
        e.ovf   = v.e_ovf;
        e.unf   = v.e_unf;
        exp_q.push_back(e);
        n_vec++;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.pc, bus.sp, bus.running, bus.stack_full, bus.stack_empty, bus.ovf_err, bus.unf_err}
                !== {e.pc, e.sp, e.run, e.full, e.empty, e.ovf, e.unf}) begin
                n_bad++;
                $display("FAIL vec%0d: got pc=%0d sp=%0d run=%b full=%b empty=%b ovf=%b unf=%b, want pc=%0d sp=%0d run=%b full=%b empty=%b ovf=%b unf=%b",
                         e.idx, bus.pc, bus.sp, bus.running, bus.stack_full, bus.stack_empty,
                         bus.ovf_err, bus.unf_err, e.pc, e.sp, e.run, e.full, e.empty, e.ovf, e.unf);
            end
        end
    end

    vec_t tbl[$];

    initial begin
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.stall  = 1'b0;
        bus.op     = NEXT;
        bus.cond   = 1'b0;
        bus.target = '0;
        bus.offset = '0;

        //           rn st sl op     c  tg    off     pc    sp  run ovf unf
        tbl.push_back(mk(0, 0, 0, NEXT,  0, 10'd0,   8'h00, 10'd0,   3'd0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, NEXT,  0, 10'd0,   8'h00, 10'd0,   3'd0, 1, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(1, 0, 0, NEXT, 0, 10'd0, 8'h00, 10'(i), 3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, JABS,  0, 10'd20,  8'h00, 10'd20,  3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, BREL,  0, 10'd0,   8'hFC, 10'd16,  3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, BRELC, 0, 10'd0,   8'hFC, 10'd17,  3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, JABSC, 1, 10'd300, 8'h00, 10'd300, 3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, BRELC, 1, 10'd0,   8'h05, 10'd305, 3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, JABSC, 0, 10'd9,   8'h00, 10'd306, 3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, BREL,  0, 10'd0,   8'h80, 10'd178, 3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, JABS,  0, 10'd10,  8'h00, 10'd10,  3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, CALL,  0, 10'd100, 8'h00, 10'd100, 3'd1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, CALL,  0, 10'd200, 8'h00, 10'd200, 3'd2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, RET,   0, 10'd0,   8'h00, 10'd101, 3'd1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, RET,   0, 10'd0,   8'h00, 10'd11,  3'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, CALL,  0, 10'd400, 8'h00, 10'd400, 3'd1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, CALL,  0, 10'd500, 8'h00, 10'd500, 3'd2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, CALL,  0, 10'd600, 8'h00, 10'd600, 3'd3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, CALL,  0, 10'd700, 8'h00, 10'd700, 3'd4, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, CALL,  0, 10'd800, 8'h00, 10'd800, 3'd4, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, RET,   0, 10'd0,   8'h00, 10'd601, 3'd3, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, RET,   0, 10'd0,   8'h00, 10'd501, 3'd2, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, RET,   0, 10'd0,   8'h00, 10'd401, 3'd1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, RET,   0, 10'd0,   8'h00, 10'd12,  3'd0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, RET,   0, 10'd0,   8'h00, 10'd13,  3'd0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, JABS,  0, 10'd1023,8'h00, 10'd1023,3'd0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, NEXT,  0, 10'd0,   8'h00, 10'd0,   3'd0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, BREL,  0, 10'd0,   8'hFE, 10'd1022,3'd0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, NEXT,  0, 10'd0,   8'h00, 10'd1023,3'd0, 1, 1, 1));

        foreach (tbl[i]) apply(tbl[i]);

        // Stall holds pc, sp and errors regardless of op.
        repeat (3) apply(mk(1, 0, 1, JABS, 0, 10'd55, 8'h00, 10'd1023, 3'd0, 1, 1, 1));
        apply(mk(1, 0, 1, CALL, 0, 10'd77, 8'h00, 10'd1023, 3'd0, 1, 1, 1));
        apply(mk(1, 0, 0, JABS, 0, 10'd55, 8'h00, 10'd55,   3'd0, 1, 1, 1));

        // HALT: ops ignored until start, which also clears sticky errors.
        apply(mk(1, 0, 0, HALT, 0, 10'd0,  8'h00, 10'd55, 3'd0, 0, 1, 1));
        apply(mk(1, 0, 0, JABS, 0, 10'd7,  8'h00, 10'd55, 3'd0, 0, 1, 1));
        apply(mk(1, 0, 0, CALL, 0, 10'd7,  8'h00, 10'd55, 3'd0, 0, 1, 1));
        apply(mk(1, 0, 1, NEXT, 0, 10'd0,  8'h00, 10'd55, 3'd0, 0, 1, 1));
        apply(mk(1, 1, 0, JABS, 0, 10'd9,  8'h00, 10'd0,  3'd0, 1, 0, 0));

        // Reset in the middle of a call sequence, then restart from IDLE.
        apply(mk(1, 0, 0, CALL, 0, 10'd100, 8'h00, 10'd100, 3'd1, 1, 0, 0));
        apply(mk(0, 0, 0, CALL, 0, 10'd200, 8'h00, 10'd0,   3'd0, 0, 0, 0));
        apply(mk(1, 0, 0, NEXT, 0, 10'd0,   8'h00, 10'd0,   3'd0, 0, 0, 0));
        apply(mk(1, 0, 0, JABS, 0, 10'd33,  8'h00, 10'd0,   3'd0, 0, 0, 0));
        apply(mk(1, 1, 1, JABS, 0, 10'd99,  8'h00, 10'd0,   3'd0, 1, 0, 0));
        apply(mk(1, 0, 0, NEXT, 0, 10'd0,   8'h00, 10'd1,   3'd0, 1, 0, 0));
        apply(mk(1, 0, 0, CALL, 0, 10'd50,  8'h00, 10'd50,  3'd1, 1, 0, 0));
        apply(mk(1, 1, 0, RET,  0, 10'd0,   8'h00, 10'd0,   3'd0, 1, 0, 0));
        apply(mk(1, 0, 0, RET,  0, 10'd0,   8'h00, 10'd1,   3'd0, 1, 0, 1));
        apply(mk(1, 1, 0, NEXT, 0, 10'd0,   8'h00, 10'd0,   3'd0, 1, 0, 0));

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
